// File: rtl/watch_pkg.sv
// Shared types and button indices for the watch UI controller.
package watch_pkg;

  typedef enum logic [2:0] {
    SHOW_TIME    = 3'd0,
    SET_HOUR     = 3'd1,
    SET_MIN      = 3'd2,
    SET_SEC      = 3'd3,
    SHOW_ALARM   = 3'd4,
    SET_ALM_HOUR = 3'd5,
    SET_ALM_MIN  = 3'd6,
    STOPWATCH    = 3'd7
  } mode_t;

  typedef enum logic [1:0] {
    FLD_NONE = 2'd0,
    FLD_HOUR = 2'd1,
    FLD_MIN  = 2'd2,
    FLD_SEC  = 2'd3
  } field_t;

  localparam logic [2:0] BTN_MODE  = 3'd0;
  localparam logic [2:0] BTN_SET   = 3'd3;
  localparam logic [2:0] BTN_UP    = 3'd4;
  localparam logic [2:0] BTN_DOWN  = 3'd5;
  localparam logic [2:0] BTN_START = 3'd6;
  localparam logic [2:0] BTN_CLEAR = 3'd7;

  function automatic logic is_alarm_edit(mode_t m);
    return (m == SET_ALM_HOUR) || (m == SET_ALM_MIN);
  endfunction

  function automatic logic is_edit(mode_t m);
    return (m == SET_HOUR) || (m == SET_MIN) || (m == SET_SEC) || is_alarm_edit(m);
  endfunction

  function automatic field_t field_of(mode_t m);
    case (m)
      SET_HOUR, SET_ALM_HOUR: return FLD_HOUR;
      SET_MIN, SET_ALM_MIN:   return FLD_MIN;
      SET_SEC:                return FLD_SEC;
      default:                return FLD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/watch_idle_timer.sv
// Counts 1 Hz ticks while enabled; pulses expired on the tick that reaches TIMEOUT_S.
module watch_idle_timer #(
  parameter int unsigned TIMEOUT_S = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = $clog2(TIMEOUT_S + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_S - 1);

  logic [W-1:0] cnt;

  // clr beats a coincident tick, so a button press on the final tick cancels expiry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (clr || !en) begin
        cnt <= '0;
      end else if (tick) begin
        cnt     <= cnt + W'(1);
        expired <= (cnt == LAST);
      end
    end
  end

endmodule

// File: rtl/watch_mode_ctrl.sv
// Watch UI sequencer: decodes button events into mode changes and edit strobes.
module watch_mode_ctrl
  import watch_pkg::*;
#(
  parameter int unsigned TIMEOUT_S = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_evt,
  input  logic [2:0] btn_id,
  input  logic       tick_1hz,
  input  logic       alarm_ringing,
  output mode_t      mode,
  output logic [1:0] edit_field,
  output logic       edit_alarm,
  output logic       inc_pls,
  output logic       dec_pls,
  output logic       sec_clr_pls,
  output logic       sw_run,
  output logic       sw_clr_pls,
  output logic       alarm_en,
  output logic       alarm_ack_pls,
  output logic       blink
);

  mode_t nxt;
  logic  inc, dec, sec_clr, sw_clr, ack, run_tgl, alm_tgl;
  logic  expired;

  // Every state change is caused either by a button event or by expiry.
  watch_idle_timer #(.TIMEOUT_S(TIMEOUT_S)) u_idle (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick_1hz),
    .clr     (btn_evt | expired),
    .en      (is_edit(mode)),
    .expired (expired)
  );

  always_comb begin
    nxt     = mode;
    inc     = 1'b0;
    dec     = 1'b0;
    sec_clr = 1'b0;
    sw_clr  = 1'b0;
    ack     = 1'b0;
    run_tgl = 1'b0;
    alm_tgl = 1'b0;
    if (btn_evt) begin
      if (alarm_ringing) begin
        ack = 1'b1;
      end else begin
        case (mode)
          SHOW_TIME: begin
            if (btn_id == BTN_MODE)     nxt = SHOW_ALARM;
            else if (btn_id == BTN_SET) nxt = SET_HOUR;
          end
          SET_HOUR, SET_MIN: begin
            case (btn_id)
              BTN_MODE: nxt = SHOW_TIME;
              BTN_SET:  nxt = (mode == SET_HOUR) ? SET_MIN : SET_SEC;
              BTN_UP:   inc = 1'b1;
              BTN_DOWN: dec = 1'b1;
              default: ;
            endcase
          end
          SET_SEC: begin
            if (btn_id == BTN_MODE || btn_id == BTN_SET)    nxt = SHOW_TIME;
            else if (btn_id == BTN_UP || btn_id == BTN_DOWN) sec_clr = 1'b1;
          end
          SHOW_ALARM: begin
            if (btn_id == BTN_MODE)       nxt = STOPWATCH;
            else if (btn_id == BTN_SET)   nxt = SET_ALM_HOUR;
            else if (btn_id == BTN_CLEAR) alm_tgl = 1'b1;
          end
          SET_ALM_HOUR, SET_ALM_MIN: begin
            case (btn_id)
              BTN_MODE: nxt = SHOW_ALARM;
              BTN_SET:  nxt = (mode == SET_ALM_HOUR) ? SET_ALM_MIN : SHOW_ALARM;
              BTN_UP:   inc = 1'b1;
              BTN_DOWN: dec = 1'b1;
              default: ;
            endcase
          end
          STOPWATCH: begin
            if (btn_id == BTN_MODE)       nxt = SHOW_TIME;
            else if (btn_id == BTN_START) run_tgl = 1'b1;
            else if (btn_id == BTN_CLEAR) sw_clr = !sw_run;
          end
          default: ;
        endcase
      end
    end else if (expired) begin
      nxt = is_alarm_edit(mode) ? SHOW_ALARM : SHOW_TIME;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode          <= SHOW_TIME;
      edit_field    <= '0;
      edit_alarm    <= 1'b0;
      inc_pls       <= 1'b0;
      dec_pls       <= 1'b0;
      sec_clr_pls   <= 1'b0;
      sw_run        <= 1'b0;
      sw_clr_pls    <= 1'b0;
      alarm_en      <= 1'b0;
      alarm_ack_pls <= 1'b0;
      blink         <= 1'b0;
    end else begin
      mode          <= nxt;
      edit_field    <= field_of(nxt);
      edit_alarm    <= is_alarm_edit(nxt);
      inc_pls       <= inc;
      dec_pls       <= dec;
      sec_clr_pls   <= sec_clr;
      sw_clr_pls    <= sw_clr;
      alarm_ack_pls <= ack;
      if (run_tgl) sw_run   <= !sw_run;
      if (alm_tgl) alarm_en <= !alarm_en;
      if (!is_edit(nxt))    blink <= 1'b0;
      else if (nxt != mode) blink <= 1'b1;
      else if (tick_1hz)    blink <= !blink;
    end
  end

endmodule

// File: doc/watch_mode_ctrl.md
# watch_mode_ctrl

Mode and edit controller for the watch. Consumes one-cycle button events from the debouncer and sequences the UI: time display, time setting, alarm display/setting, and stopwatch. Issues single-cycle increment/decrement/clear strobes to the timekeeping, alarm and stopwatch datapaths, and drives display mode, edit-field select and blink. Sits between the button debouncer and the counter datapaths.

## Interface
- TIMEOUT_S, 30: idle seconds in an edit state before automatic exit; legal range 1..255.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- btn_evt  in  1  one-cycle strobe: a debounced button press.
- btn_id  in  3  button index, valid when btn_evt=1; 0=MODE, 3=SET, 4=UP, 5=DOWN, 6=START, 7=CLEAR; 1 and 2 are unassigned.
- tick_1hz  in  1  one-cycle strobe, once per second.
- alarm_ringing  in  1  level; alarm currently sounding.
- mode  out  3  current state, encoded as mode_t.
- edit_field  out  2  0=none, 1=hour, 2=minute, 3=second.
- edit_alarm  out  1  1 = edit strobes target the alarm registers; 0 = the time registers.
- inc_pls, dec_pls  out  1  one-cycle increment/decrement of the selected field.
- sec_clr_pls  out  1  one-cycle "zero the seconds" strobe.
- sw_run  out  1  stopwatch running level.
- sw_clr_pls  out  1  one-cycle stopwatch clear.
- alarm_en  out  1  alarm armed level.
- alarm_ack_pls  out  1  one-cycle alarm silence.
- blink  out  1  display blink phase for the edited field.

## Operation
- States: SHOW_TIME, SET_HOUR, SET_MIN, SET_SEC, SHOW_ALARM, SET_ALM_HOUR, SET_ALM_MIN, STOPWATCH.
- SHOW_TIME:
  - MODE goes to SHOW_ALARM.
  - SET goes to SET_HOUR.
- SET_HOUR: SET goes to SET_MIN. SET_MIN: SET goes to SET_SEC. SET_SEC: SET goes to SHOW_TIME.
- SET_HOUR and SET_MIN:
  - UP gives inc_pls; DOWN gives dec_pls.
  - edit_field is 1 in SET_HOUR and 2 in SET_MIN; edit_alarm=0.
- SET_SEC: UP or DOWN gives sec_clr_pls. edit_field=3.
- In any time-edit state, MODE aborts to SHOW_TIME. Strobes already issued are not undone.
- SHOW_ALARM:
  - MODE goes to STOPWATCH.
  - SET goes to SET_ALM_HOUR.
  - CLEAR toggles alarm_en.
- SET_ALM_HOUR: SET goes to SET_ALM_MIN. SET_ALM_MIN: SET goes to SHOW_ALARM.
- In the alarm-edit states, UP/DOWN give inc_pls/dec_pls, edit_alarm=1, and MODE aborts to SHOW_ALARM.
- STOPWATCH:
  - MODE goes to SHOW_TIME.
  - START toggles sw_run.
  - CLEAR gives sw_clr_pls only while sw_run=0; it is ignored while running.
  - sw_run is not changed by leaving STOPWATCH; the stopwatch keeps running in the background.
- Alarm silence has priority over all state decoding. If alarm_ringing=1, any btn_evt produces alarm_ack_pls only: no state change, no other strobe.
- Unassigned ids (1, 2), and ids with no meaning in the current state, cause no state change and no strobe. They still reset the idle counter.
- Idle timeout (edit states only):
  - The idle counter, $clog2(TIMEOUT_S+1) bits wide, increments on tick_1hz.
  - It clears on any btn_evt and on every state change.
  - When it reaches TIMEOUT_S, the FSM returns to SHOW_TIME (time edits) or SHOW_ALARM (alarm edits).
  - If btn_evt and tick_1hz arrive in the same cycle, the event wins: the counter clears and the event is decoded normally.
- blink:
  - Forced to 1 on entering an edit state.
  - Toggles on each tick_1hz while in an edit state.
  - 0 in every non-edit state.

## Timing
- All outputs are registered.
- btn_evt sampled at edge N: mode, edit_field, edit_alarm and levels are updated at edge N+1, and strobes are high for exactly cycle N+1 to N+2. Latency is 1 cycle.
- Back-to-back btn_evt on consecutive cycles are each decoded against the state left by the previous event.
- Timeout exit takes effect one cycle after the tick that reaches TIMEOUT_S.
- Reset values: mode=SHOW_TIME, edit_field=0, edit_alarm=0, every *_pls=0, sw_run=0, alarm_en=0, blink=0, idle counter=0.
- Reset asserted mid-edit: all outputs return to the reset values immediately (asynchronous). No strobe is emitted on release.

## Structure
- Package watch_pkg holds:
  - mode_t enum (8 states, 3 bits);
  - field_t (2 bits);
  - button-index localparams BTN_MODE=0, BTN_SET=3, BTN_UP=4, BTN_DOWN=5, BTN_START=6, BTN_CLEAR=7.
- One sub-module, watch_idle_timer:
  - parameter TIMEOUT_S;
  - inputs clk, rst_n, tick, clr, en;
  - output expired, a one-cycle strobe.
- The FSM, strobe generation and blink logic stay in watch_mode_ctrl.

## Test plan
- Reset, then SET, UP, UP, SET, DOWN, SET, UP, SET -> mode sequence SET_HOUR, SET_MIN, SET_SEC, SHOW_TIME. Strobe pattern:
  - two inc_pls with edit_field=1;
  - one dec_pls with edit_field=2;
  - one sec_clr_pls.
- MODE, CLEAR, SET, UP -> SHOW_ALARM with alarm_en=1, then SET_ALM_HOUR; inc_pls with edit_alarm=1.
- MODE ×2 to STOPWATCH, then START, CLEAR, START, CLEAR ->
  - sw_run goes 1, 0;
  - the first CLEAR is ignored, the second gives one sw_clr_pls;
  - MODE then leaves sw_run unchanged.
- TIMEOUT_S=3, enter SET_MIN, then three tick_1hz -> mode returns to SHOW_TIME one cycle after the third tick. Repeat with btn_evt(UP) coincident with the third tick -> stays in SET_MIN and inc_pls is issued.
- alarm_ringing=1 in SET_HOUR, press UP -> alarm_ack_pls only: no inc_pls, mode unchanged.
- Assert rst_n low during SET_ALM_MIN with blink=1 -> all outputs return to reset values immediately. btn_id=1 events after release -> no output change.
